// File: rtl/sprite_rom_pkg.sv
// Shared widths, pipeline tag and helpers for the sprite ROM arbiter.
package sprite_rom_pkg;

    localparam int ROM_ADDR_WIDTH = 20;
    localparam int ROM_DATA_WIDTH = 12;
    localparam int ROM_LATENCY    = 1;
    localparam int N_REQ_MAX      = 4;
    localparam int ID_WIDTH       = $clog2(N_REQ_MAX);

    typedef logic [ID_WIDTH-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rsp_tag_t;

    // Successor of a requester index, wrapping at n.
    function automatic req_id_t next_id(input req_id_t id, input int n);
        if (int'(id) >= n - 1) begin
            return '0;
        end else begin
            return id + req_id_t'(1'b1);
        end
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_arbiter.sv
// Rotate-priority pick: first valid requester at or after rr_ptr, wrapping.
module rr_arbiter
    import sprite_rom_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic [ID_WIDTH-1:0] grant_idx,
    output logic                found
);

    int cand_s;

    // Scan candidates rr_ptr, rr_ptr+1, ... and keep the first valid one.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand_s    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = int'(rr_ptr) + k;
            if (cand_s >= N_REQ) begin
                cand_s = cand_s - N_REQ;
            end else begin
                cand_s = cand_s;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && (i == cand_s) && req_valid[i]) begin
                    found     = 1'b1;
                    grant_idx = ID_WIDTH'(i);
                end else begin
                    found     = found;
                end
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one 1-cycle-latency sprite ROM between N_REQ drawers: round-robin
// grant with bounded burst lock, and a 2-cycle tagged response pipeline.
module sprite_rom_arbiter
    import sprite_rom_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
    parameter int DATA_WIDTH = ROM_DATA_WIDTH,
    parameter int LOCK_MAX   = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ-1:0]            req_lock,
    output logic [N_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]       rom_addr,
    input  logic [DATA_WIDTH-1:0]       rom_dout,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_data
);

    localparam int                   CNT_WIDTH  = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_WIDTH-1:0] LOCK_LIMIT = CNT_WIDTH'(LOCK_MAX);

    req_id_t                rr_ptr_r;
    logic                   owner_vld_r;
    req_id_t                owner_r;
    logic [CNT_WIDTH-1:0]   lock_cnt_r;
    rsp_tag_t               tag_r;
    logic [N_REQ-1:0]       rsp_valid_r;
    logic [DATA_WIDTH-1:0]  rsp_data_r;

    req_id_t                rr_idx_s;
    logic                   rr_found_s;
    logic                   owner_req_s;
    logic                   lock_hit_s;
    logic                   grant_s;
    req_id_t                grant_idx_s;
    logic [N_REQ-1:0]       ready_s;
    logic [ADDR_WIDTH-1:0]  rom_addr_s;
    logic                   lock_req_s;
    logic [CNT_WIDTH-1:0]   next_cnt_s;
    logic [N_REQ-1:0]       rsp_hot_s;

    rr_arbiter #(
        .N_REQ     (N_REQ)
    ) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_r),
        .grant_idx (rr_idx_s),
        .found     (rr_found_s)
    );

    // Lock owner keeps the grant while still requesting and under its burst budget.
    always_comb begin
        owner_req_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if ((owner_r == ID_WIDTH'(i)) && req_valid[i]) begin
                owner_req_s = 1'b1;
            end else begin
                owner_req_s = owner_req_s;
            end
        end
        lock_hit_s = owner_vld_r && owner_req_s && (lock_cnt_r < LOCK_LIMIT);
        if (lock_hit_s) begin
            grant_idx_s = owner_r;
            grant_s     = !rst;
        end else begin
            grant_idx_s = rr_idx_s;
            grant_s     = rr_found_s && !rst;
        end
    end

    // Decode the grant into ready, ROM address and the winner's lock request.
    always_comb begin
        ready_s    = '0;
        rom_addr_s = '0;
        lock_req_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_s && (grant_idx_s == ID_WIDTH'(i))) begin
                ready_s[i] = 1'b1;
                rom_addr_s = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                lock_req_s = req_lock[i];
            end else begin
                ready_s[i] = 1'b0;
            end
        end
        if (owner_vld_r && (owner_r == grant_idx_s)) begin
            next_cnt_s = lock_cnt_r + CNT_WIDTH'(1'b1);
        end else begin
            next_cnt_s = CNT_WIDTH'(1'b1);
        end
    end

    // One-hot response strobe from the stage-1 tag.
    always_comb begin
        rsp_hot_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_hot_s[i] = tag_r.valid && (tag_r.id == ID_WIDTH'(i));
        end
    end

    // Round-robin pointer and burst lock; reaching the budget drops the lock so rotation moves on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r    <= '0;
            owner_vld_r <= 1'b0;
            owner_r     <= '0;
            lock_cnt_r  <= '0;
        end else if (grant_s) begin
            rr_ptr_r <= next_id(grant_idx_s, N_REQ);
            if (lock_req_s && (next_cnt_s < LOCK_LIMIT)) begin
                owner_vld_r <= 1'b1;
                owner_r     <= grant_idx_s;
                lock_cnt_r  <= next_cnt_s;
            end else begin
                owner_vld_r <= 1'b0;
                owner_r     <= '0;
                lock_cnt_r  <= '0;
            end
        end else begin
            owner_vld_r <= 1'b0;
            owner_r     <= '0;
            lock_cnt_r  <= '0;
        end
    end

    // Response pipeline: tag alongside the ROM read, then register data and strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_r       <= '0;
            rsp_valid_r <= '0;
            rsp_data_r  <= '0;
        end else begin
            tag_r.valid <= grant_s;
            tag_r.id    <= grant_idx_s;
            rsp_valid_r <= rsp_hot_s;
            if (tag_r.valid) begin
                rsp_data_r <= rom_dout;
            end else begin
                rsp_data_r <= rsp_data_r;
            end
        end
    end

    assign req_ready = ready_s;
    assign rom_addr  = rom_addr_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed plus randomized bench for sprite_rom_arbiter against a behavioural model.
module tb_sprite_rom_arbiter;

    localparam int N  = 2;
    localparam int AW = 20;
    localparam int DW = 12;
    localparam int LM = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_lock;
    logic [N-1:0]    req_ready;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_dout;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;

    int checks = 0;
    int errors = 0;

    // Model state: pointer, lock owner (-1 none), burst count, two-deep response history.
    int            m_ptr, m_owner, m_cnt;
    int            h1_id, h2_id;
    logic [DW-1:0] h1_d, h2_d;
    logic [N-1:0]  obs_ready;

    always #5 clk = ~clk;

    // ROM model: rom[a] = a[11:0], one cycle latency.
    always @(posedge clk) rom_dout <= rom_addr[DW-1:0];

    sprite_rom_arbiter #(
        .N_REQ      (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LOCK_MAX   (LM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    function automatic int model_pick();
        if (m_owner >= 0 && req_valid[m_owner] && m_cnt < LM) return m_owner;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_owner = -1; m_cnt = 0;
        h1_id = -1; h2_id = -1; h1_d = '0; h2_d = '0;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        req_valid = v;
        req_lock  = l;
        req_addr  = {a1, a0};
    endtask

    // One clock cycle: check grant/address/response mid-cycle, then advance the model.
    task automatic step();
        int            g, c;
        logic [N-1:0]  exp_ready, exp_rsp;
        logic [AW-1:0] exp_addr;
        #3;
        g = model_pick();
        exp_ready = '0;
        exp_addr  = '0;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            exp_addr     = addr_of(g);
        end
        obs_ready = req_ready;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rom_addr", 32'(rom_addr), 32'(exp_addr));
        if (h2_id >= 0) begin
            exp_rsp = '0;
            exp_rsp[h2_id] = 1'b1;
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
            check("rsp_data", 32'(rsp_data), 32'(h2_d));
        end else begin
            check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        h2_id = h1_id;
        h2_d  = h1_d;
        h1_id = g;
        h1_d  = exp_addr[DW-1:0];
        if (g >= 0) begin
            m_ptr = (g + 1) % N;
            if (req_lock[g]) begin
                c = (m_owner == g) ? m_cnt + 1 : 1;
                if (c >= LM) begin
                    m_owner = -1; m_cnt = 0;
                end else begin
                    m_owner = g; m_cnt = c;
                end
            end else begin
                m_owner = -1; m_cnt = 0;
            end
        end else begin
            m_owner = -1; m_cnt = 0;
        end
        #1;
    endtask

    logic [N-1:0] t3_pat [6];

    initial begin
        t3_pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
        rst = 1'b1;
        drive(2'b00, 2'b00, 20'h0, 20'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        req_valid = 2'b11;
        #1;
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        rst = 1'b0;
        drive(2'b00, 2'b00, 20'h0, 20'h0);
        @(posedge clk);
        #1;

        // Single read from req0.
        drive(2'b01, 2'b00, 20'h00010, 20'h0);
        step();
        drive(2'b00, 2'b00, 20'h0, 20'h0);
        repeat (3) step();

        // Both valid, no lock: alternate.
        drive(2'b11, 2'b00, 20'h00100, 20'h00200);
        repeat (8) step();
        drive(2'b10, 2'b00, 20'h0, 20'h00210);
        step();

        // Locked burst from req0 bounded at LM grants.
        drive(2'b11, 2'b01, 20'h00300, 20'h00400);
        for (int k = 0; k < 6; k++) begin
            step();
            check("t3_grant", 32'(obs_ready), 32'(t3_pat[k]));
        end

        // Lone locked requester keeps the grant past LM.
        drive(2'b10, 2'b10, 20'h0, 20'h00555);
        for (int k = 0; k < 10; k++) begin
            step();
            check("t4_grant", 32'(obs_ready), 32'(2'b10));
        end
        drive(2'b00, 2'b00, 20'h0, 20'h0);
        repeat (2) step();

        // Reset mid-flight drops the pending response.
        drive(2'b01, 2'b00, 20'h000AB, 20'h0);
        step();
        drive(2'b00, 2'b00, 20'h0, 20'h0);
        #4;
        rst = 1'b1;
        req_valid = 2'b11;
        #1;
        check("t5_ready_in_reset", 32'(req_ready), 32'd0);
        check("t5_rsp_in_reset", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        check("t5_no_stale", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        model_reset();
        drive(2'b00, 2'b00, 20'h0, 20'h0);
        repeat (3) step();
        drive(2'b11, 2'b00, 20'h00777, 20'h00888);
        step();
        check("t5_ptr_zero", 32'(obs_ready), 32'(2'b01));
        repeat (2) step();

        // Lock dies on an idle cycle; rotation then favours req1.
        drive(2'b01, 2'b01, 20'h00600, 20'h0);
        repeat (2) step();
        drive(2'b00, 2'b00, 20'h0, 20'h0);
        step();
        drive(2'b11, 2'b01, 20'h00601, 20'h00701);
        step();
        check("t6_req1_first", 32'(obs_ready), 32'(2'b10));
        drive(2'b00, 2'b00, 20'h0, 20'h0);
        repeat (2) step();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [N-1:0] v, l;
            v = N'($urandom_range(0, 3));
            l[0] = ($urandom_range(0, 9) < 7);
            l[1] = ($urandom_range(0, 9) < 7);
            drive(v, l, AW'($urandom), AW'($urandom));
            step();
        end
        drive(2'b00, 2'b00, 20'h0, 20'h0);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
